// File: rtl/gate_op_arbiter.sv
// Round-robin sharing of one bitwise gate unit (AND/OR/XOR/NAND) among NREQ lanes.
// Optional GATE_OP_ARB_STATS_EN adds the done_count and busy outputs.
module gate_op_arbiter #(
    parameter int  NREQ = 4,
    parameter int  W    = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data
`ifdef GATE_OP_ARB_STATS_EN
    ,
    output logic [15:0]       done_count,
    output logic              busy
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] g_reg;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand;
    logic           grant_found;
    logic           accept;
    logic           done;
    logic [1:0]     op_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   gate_y;

    logic [1:0]     op_arr [NREQ];
    logic [W-1:0]   a_arr  [NREQ];
    logic [W-1:0]   b_arr  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[2*i +: 2];
        assign a_arr[i]  = req_a[W*i +: W];
        assign b_arr[i]  = req_b[W*i +: W];
    end

    // First valid lane at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_found && rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_nx             = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gate_y = '0;
        unique case (op_reg)
            2'b00: gate_y = a_reg & b_reg;
            2'b01: gate_y = a_reg | b_reg;
            2'b10: gate_y = a_reg ^ b_reg;
            2'b11: gate_y = ~(a_reg & b_reg);
            default: gate_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            g_reg     <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (accept) begin
                g_reg  <= grant_idx;
                op_reg <= op_arr[grant_idx];
                a_reg  <= a_arr[grant_idx];
                b_reg  <= b_arr[grant_idx];
            end
            if (state == EXEC) begin
                rsp_data  <= gate_y;
                rsp_id    <= g_reg;
                rsp_valid <= 1'b1;
            end
            if (done) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (g_reg == IDW'(NREQ-1)) ? '0 : g_reg + 1'b1;
            end
        end
    end

`ifdef GATE_OP_ARB_STATS_EN
    // Saturating completion counter; holds at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_count <= '0;
        end else if (done && done_count != 16'hFFFF) begin
            done_count <= done_count + 16'd1;
        end
    end

    assign busy = (state != IDLE);
`endif

endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Shares one W-bit bitwise logic unit (AND/OR/XOR/NAND) among NREQ requesters using round-robin arbitration.
- Each requester presents an opcode and two operands with a valid/ready handshake. The result is returned on one shared response channel, tagged with the requester ID.
- Sits between the per-lane stimulus generators and the shared gate datapath. The gate datapath is instantiated inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits
- IDW, $clog2(NREQ), requester ID width (derived, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept strobe
- req_op  input  2*NREQ  opcode per requester, slice i = [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 NAND
- req_a  input  W*NREQ  operand A per requester, slice i = [W*i+W-1:W*i]
- req_b  input  W*NREQ  operand B per requester, same slicing
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  IDW  index of the requester that owns the response
- rsp_data  output  W  result

Behaviour:
- Reset is asynchronous on rst_n low:
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - req_ready=0 while rst_n=0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Grant is combinational. Search starts at rr_ptr and goes upward with wrap; the first i with req_valid[i]=1 wins.
  - req_ready[g]=1 only for the winner and only in IDLE. It is one-hot or all-zero.
  - When req_valid[g]&req_ready[g] is true, op/a/b/g are captured into registers and the FSM goes to EXEC.
  - With no valid requests, the FSM stays in IDLE and req_ready=0.
- EXEC:
  - rsp_data <= op(a_reg,b_reg), bitwise across W bits. NAND = ~(a&b).
  - rsp_id <= g_reg, rsp_valid <= 1, then go to RESP.
  - req_ready=0.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1.
  - On rsp_valid&rsp_ready, clear rsp_valid, set rr_ptr <= (g_reg+1) mod NREQ and return to IDLE.
  - req_ready=0 throughout RESP.
- Latency: acceptance in cycle T gives rsp_valid=1 in cycle T+2. If rsp_ready is held high, the next acceptance happens in T+3, so peak throughput is 1 op per 3 cycles.
- Fairness: a requester that holds req_valid is granted within NREQ grants.
- Requests may be withdrawn (req_valid dropped) while not yet accepted; no state is affected.
- Operands are sampled only at acceptance. Later changes on req_a/req_b/req_op do not affect an in-flight result.
- rsp_ready high during IDLE or EXEC is ignored.
- A single requester asserting continuously is served back-to-back; rr_ptr wraps from NREQ-1 to 0.
- Reset asserted mid-operation (EXEC or RESP) abandons the operation immediately. No response is emitted after reset release.

Optional Feature:
- Macro: GATE_OP_ARB_STATS_EN.
- Defined:
  - Adds output done_count, 16 bits, reset 0.
  - It increments by 1 on every rsp_valid&rsp_ready and saturates at 16'hFFFF, never wrapping.
  - Adds output busy, 1 bit, equal to (state!=IDLE).
- Not defined: neither port exists and there is no counter logic.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release, all req_valid=0 for 10 cycles -> rsp_valid=0, req_ready=0 throughout.
- Single op per opcode: requester 1, a=8'hCC, b=8'hAA, rsp_ready=1:
  - op 00 -> rsp_data=8'h88, rsp_id=1, exactly 2 cycles after acceptance.
  - op 01 -> 8'hEE.
  - op 10 -> 8'h66.
  - op 11 -> 8'h77.
- Round-robin: all 4 requesters valid continuously with distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0.
  - Each rsp_id matches the requester's expected result.
  - One acceptance every 3 cycles.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises:
  - rsp_valid, rsp_id and rsp_data stay stable.
  - req_ready=0 for all requesters.
  - After rsp_ready=1 the next grant occurs in the following IDLE cycle.
- Operand change after accept: requester 2 accepted with a=8'hF0, b=8'h0F, op=01, then req_a changed to 8'h00 -> rsp_data=8'hFF.
- Reset mid-flight: rst_n pulsed low while in RESP -> rsp_valid=0 immediately, rr_ptr=0.
  - After release with req 0 and req 3 valid, requester 0 is granted first.
  - With GATE_OP_ARB_STATS_EN defined, done_count=0.
